// File: rtl/fast_stream_ctrl.sv
// rtl/fast_stream_ctrl.sv - pixel stream sequencer feeding the 7x7 FAST line buffer
// Gates the line-buffer clock-enable on back-pressure, appends a zero flush tail, checks framing.
module fast_stream_ctrl #(
    parameter int COL_NUM     = 640,
    parameter int ROW_NUM     = 480,
    parameter int PIXEL_WIDTH = 8,
    parameter int FLUSH_CYC   = 3*COL_NUM+11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [PIXEL_WIDTH-1:0] s_data,
    input  logic                   s_sof,
    input  logic                   s_eol,
    input  logic                   m_ready,
    output logic                   lb_ce,
    output logic [PIXEL_WIDTH-1:0] lb_data,
    output logic                   busy,
    output logic                   frame_done,
    output logic [15:0]            frame_cnt,
    output logic                   err_sof,
    output logic                   err_eol,
    input  logic                   err_clr
);

    localparam int COL_W = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
    localparam int ROW_W = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
    localparam int FL_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COL_NUM - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_NUM - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [COL_W-1:0] r_col_cnt;
    logic [ROW_W-1:0] r_row_cnt;
    logic [FL_W-1:0]  r_flush_cnt;
    logic [15:0]      r_frame_cnt;
    logic             r_frame_done;
    logic             r_err_sof;
    logic             r_err_eol;

    logic             w_last_col;
    logic             w_last_row;
    logic             w_flush_last;
    logic             w_set_sof;
    logic             w_set_eol;
    logic             w_done_exit;

    assign w_last_col   = (r_col_cnt == COL_LAST);
    assign w_last_row   = (r_row_cnt == ROW_LAST);
    assign w_flush_last = (r_flush_cnt == FL_LAST);
    assign w_done_exit  = (r_state == S_DONE);

    assign busy       = (r_state == S_STREAM) || (r_state == S_FLUSH);
    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;
    assign err_sof    = r_err_sof;
    assign err_eol    = r_err_eol;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        s_ready   = 1'b0;
        lb_ce     = 1'b0;
        lb_data   = '0;
        w_set_sof = 1'b0;
        w_set_eol = 1'b0;
        case (r_state)
            S_IDLE: begin
                s_ready = enable && m_ready;
                lb_data = s_data;
                if (s_valid && enable && m_ready) begin
                    if (s_sof) begin
                        lb_ce  = 1'b1;
                        w_next = S_STREAM;
                    end else begin
                        w_set_sof = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                s_ready = m_ready;
                lb_data = s_data;
                lb_ce   = s_valid && m_ready;
                if (s_valid && m_ready) begin
                    w_set_sof = s_sof;
                    w_set_eol = (s_eol != w_last_col);
                    if (w_last_col && w_last_row) begin
                        w_next = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                lb_ce = m_ready;
                if (m_ready && w_flush_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Counters only move on an enabled pipeline step, so m_ready low freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_cnt    <= '0;
            r_row_cnt    <= '0;
            r_flush_cnt  <= '0;
            r_frame_cnt  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= (w_next == S_DONE);
            r_frame_cnt  <= r_frame_cnt + {15'd0, w_done_exit};
            case (r_state)
                S_IDLE: begin
                    if (lb_ce) begin
                        if (COL_NUM == 1) begin
                            r_col_cnt <= '0;
                            r_row_cnt <= ROW_W'(1);
                        end else begin
                            r_col_cnt <= COL_W'(1);
                            r_row_cnt <= '0;
                        end
                    end
                end
                S_STREAM: begin
                    if (lb_ce) begin
                        if (w_last_col) begin
                            r_col_cnt <= '0;
                            if (w_last_row) begin
                                r_row_cnt   <= '0;
                                r_flush_cnt <= '0;
                            end else begin
                                r_row_cnt <= r_row_cnt + ROW_W'(1);
                            end
                        end else begin
                            r_col_cnt <= r_col_cnt + COL_W'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (lb_ce) begin
                        r_flush_cnt <= r_flush_cnt + FL_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A new error in the same cycle as err_clr wins so it is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sof <= 1'b0;
            r_err_eol <= 1'b0;
        end else begin
            if (w_set_sof) begin
                r_err_sof <= 1'b1;
            end else if (err_clr) begin
                r_err_sof <= 1'b0;
            end
            if (w_set_eol) begin
                r_err_eol <= 1'b1;
            end else if (err_clr) begin
                r_err_eol <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fast_stream_ctrl.md
Name: fast_stream_ctrl

Overview:
- Sequencer in front of the 7x7 FAST line-buffer/patch generator.
- Accepts a pixel stream with valid/ready and start-of-frame/end-of-line markers, and produces the line buffer's clock-enable and pixel input.
- Stalls the pipeline on downstream back-pressure.
- Appends a zero-pixel flush tail after each frame so the last patches and delayed coordinates drain, then checks stream framing and reports frame completion.

Parameters:
COL_NUM, 640, pixels per line.
ROW_NUM, 480, lines per frame.
PIXEL_WIDTH, 8, pixel bit width.
FLUSH_CYC, 3*COL_NUM+11, enabled cycles of zero data appended after the last pixel of a frame; must be ≥1.

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
enable  in  1  permits starting a new frame; sampled only in IDLE.
s_valid  in  1  input pixel valid.
s_ready  out  1  input pixel accepted when s_valid&&s_ready.
s_data  in  PIXEL_WIDTH  input pixel.
s_sof  in  1  marks first pixel of a frame.
s_eol  in  1  marks last pixel of a line.
m_ready  in  1  downstream (FAST scorer) can absorb a pipeline step.
lb_ce  out  1  clock-enable to line buffer.
lb_data  out  PIXEL_WIDTH  pixel to line buffer.
busy  out  1  high in STREAM or FLUSH.
frame_done  out  1  one-cycle pulse at end of flush.
frame_cnt  out  16  completed frames; wraps at 65535→0.
err_sof  out  1  sticky framing error: unexpected SOF, or data before SOF.
err_eol  out  1  sticky framing error: EOL misplaced.
err_clr  in  1  synchronous clear of both error flags.

Behaviour:
- Reset (rst_n low, async): state=IDLE; col_cnt, row_cnt, flush_cnt, frame_cnt, err_sof, err_eol, frame_done all 0.
  - Combinational outputs then evaluate as in IDLE.
  - Reset mid-frame abandons the frame; no frame_done.
- States: IDLE, STREAM, FLUSH, DONE.
- IDLE:
  - s_ready = enable && m_ready.
  - Accepted beat with s_sof=1: lb_ce=1, lb_data=s_data, col_cnt←1 (or 0 with row_cnt←1 if COL_NUM=1), state→STREAM.
  - Accepted beat with s_sof=0: discarded (lb_ce=0), err_sof←1.
- STREAM:
  - s_ready = m_ready.
  - lb_ce = s_valid && m_ready; lb_data = s_data.
  - Each accepted beat advances col_cnt; at COL_NUM-1, col_cnt wraps to 0 and row_cnt increments.
  - Accepted beat with s_sof=1 sets err_sof; the counters are not resynchronised.
  - Accepted beat with s_eol ≠ (col_cnt==COL_NUM-1) sets err_eol; the counters are not resynchronised.
  - The accepted beat at (col_cnt=COL_NUM-1, row_cnt=ROW_NUM-1): row_cnt←0, col_cnt←0, flush_cnt←0, state→FLUSH.
- FLUSH:
  - s_ready=0; lb_ce=m_ready; lb_data=0.
  - flush_cnt increments on each lb_ce. The lb_ce cycle with flush_cnt==FLUSH_CYC-1 moves state→DONE.
- DONE (exactly one cycle):
  - s_ready=0, lb_ce=0.
  - frame_done registered high during this cycle; frame_cnt increments on exit.
  - state→IDLE.
- Signal timing:
  - lb_ce and lb_data are combinational from state/inputs (same-cycle as accept).
  - err_*, frame_done and frame_cnt are registered.
- busy = (state==STREAM || state==FLUSH).
- Error flags:
  - err_clr clears both flags; a simultaneous set takes priority over err_clr.
  - Errors never alter the state sequence.
- m_ready low freezes the pipeline: lb_ce=0, no counters change, s_ready=0.
- enable dropping mid-frame has no effect; the current frame completes.

Test Plan (COL_NUM=8, ROW_NUM=4, FLUSH_CYC=5 unless noted):
- Clean frame:
  - Stimulus: 32 beats, s_valid held, s_sof on beat 0, s_eol on beats 7,15,23,31, m_ready=1.
  - Response: lb_ce high 32+5=37 consecutive cycles; lb_data=0 on the last 5; frame_done pulses once on the next cycle; frame_cnt=1; no errors.
- Back-pressure:
  - Stimulus: clean frame with m_ready low every 3rd cycle.
  - Response: lb_ce total count still 37; s_ready=0 exactly when m_ready=0; frame_done after the 37th lb_ce.
- Framing errors:
  - Pre-SOF beat in IDLE → discarded, err_sof=1, lb_ce=0.
  - s_eol on beat 5 → err_eol=1; frame still completes after 32 beats.
  - Pulsing err_clr → both flags 0.
- Async reset:
  - Stimulus: assert rst_n low during FLUSH at flush_cnt=2.
  - Response: immediately busy=0 and frame_cnt unchanged; the next SOF frame completes normally.
- Enable gating:
  - enable=0 in IDLE with an s_sof beat waiting → s_ready=0, no lb_ce.
  - Raising enable → the frame is accepted.
  - Deasserting enable mid-frame → the frame still finishes.
- frame_cnt wrap:
  - Stimulus: force frame_cnt to 65535, then run a clean frame.
  - Response: frame_cnt=0 and frame_done still pulses.
